// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
// Covers the deserialiser states, error causes and scan-code prefixes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [1:0] PS2_ERR_PARITY  = 2'b01;
    localparam logic [1:0] PS2_ERR_FRAME   = 2'b10;
    localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;

    // A PS/2 frame carries odd parity over the eight data bits plus the parity bit.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Bundle of the PS/2 pin inputs and the byte/key event outputs of ps2_rx.
// The slave side is the receiver; the master side drives the pins and consumes events.
interface ps2_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_err;
    logic [1:0] rx_err_code;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_released;
    logic       busy;

    modport master (
        output ps2_clk, ps2_data,
        input  rx_byte, rx_strobe, rx_err, rx_err_code,
        input  key_strobe, key_code, key_ext, key_released, busy
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output rx_byte, rx_strobe, rx_err, rx_err_code,
        output key_strobe, key_code, key_ext, key_released, busy
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// Synchronises and deglitches the PS/2 pins, then deserialises one 11-bit frame
// per falling clock edge, with an inactivity timeout that aborts a stalled frame.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_err,
    output logic [1:0] rx_err_code,
    output logic       busy
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f, clk_f_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    ps2_state_t    state, state_n;
    logic [7:0]    sr, sr_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          par_bit, par_bit_n;
    logic [TW-1:0] to_cnt, to_cnt_n, to_inc;
    logic [7:0]    rx_byte_n;
    logic          rx_strobe_n, rx_err_n;
    logic [1:0]    rx_err_code_n;

    // The filtered clock only follows the synced pin after FILTER consecutive disagreeing samples.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            clk_f      <= 1'b1;
            clk_f_prev <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            dat_s1     <= ps2_data;
            dat_s2     <= dat_s1;
            clk_f_prev <= clk_f;
            if (clk_s2 != clk_f) begin
                if (filt_cnt == FW'(FILTER - 1)) begin
                    clk_f    <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall   = clk_f_prev & ~clk_f;
    assign to_inc = to_cnt + 1'b1;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            rx_byte     <= '0;
            rx_strobe   <= 1'b0;
            rx_err      <= 1'b0;
            rx_err_code <= '0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            bit_cnt     <= bit_cnt_n;
            par_bit     <= par_bit_n;
            to_cnt      <= to_cnt_n;
            rx_byte     <= rx_byte_n;
            rx_strobe   <= rx_strobe_n;
            rx_err      <= rx_err_n;
            rx_err_code <= rx_err_code_n;
        end
    end

    // A falling edge always takes priority over a timeout expiring in the same cycle.
    always_comb begin
        state_n       = state;
        sr_n          = sr;
        bit_cnt_n     = bit_cnt;
        par_bit_n     = par_bit;
        to_cnt_n      = to_cnt;
        rx_byte_n     = rx_byte;
        rx_strobe_n   = 1'b0;
        rx_err_n      = 1'b0;
        rx_err_code_n = rx_err_code;
        if (fall) begin
            to_cnt_n = '0;
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    sr_n      = {dat_s2, sr[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_bit_n = dat_s2;
                    state_n   = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (dat_s2 && ps2_parity_ok(sr, par_bit)) begin
                        rx_byte_n   = sr;
                        rx_strobe_n = 1'b1;
                    end else if (!ps2_parity_ok(sr, par_bit)) begin
                        rx_err_n      = 1'b1;
                        rx_err_code_n = PS2_ERR_PARITY;
                    end else begin
                        rx_err_n      = 1'b1;
                        rx_err_code_n = PS2_ERR_FRAME;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (to_inc == TW'(TIMEOUT)) begin
                state_n       = IDLE;
                to_cnt_n      = '0;
                rx_err_n      = 1'b1;
                rx_err_code_n = PS2_ERR_TIMEOUT;
            end else begin
                to_cnt_n = to_inc;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver top: frame deserialiser plus a prefix decoder that folds
// E0 (extended) and F0 (release) prefixes into single key events.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic     clk_sys,
    input  logic     reset,
    ps2_rx_if.slave  bus
);

    logic [7:0] rx_byte;
    logic       rx_strobe, rx_err;
    logic       ext_f, rel_f;
    logic       key_strobe, key_ext, key_released;
    logic [7:0] key_code;

    ps2_rx_frame #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) u_frame (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_clk     (bus.ps2_clk),
        .ps2_data    (bus.ps2_data),
        .rx_byte     (rx_byte),
        .rx_strobe   (rx_strobe),
        .rx_err      (rx_err),
        .rx_err_code (bus.rx_err_code),
        .busy        (bus.busy)
    );

    // Prefix flags accumulate until a non-prefix byte consumes them; any dropped frame forgets them.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ext_f        <= 1'b0;
            rel_f        <= 1'b0;
            key_strobe   <= 1'b0;
            key_code     <= '0;
            key_ext      <= 1'b0;
            key_released <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (rx_err) begin
                ext_f <= 1'b0;
                rel_f <= 1'b0;
            end else if (rx_strobe) begin
                if (rx_byte == PS2_PFX_EXT) begin
                    ext_f <= 1'b1;
                end else if (rx_byte == PS2_PFX_REL) begin
                    rel_f <= 1'b1;
                end else begin
                    key_strobe   <= 1'b1;
                    key_code     <= rx_byte;
                    key_ext      <= ext_f;
                    key_released <= rel_f;
                    ext_f        <= 1'b0;
                    rel_f        <= 1'b0;
                end
            end
        end
    end

    assign bus.rx_byte      = rx_byte;
    assign bus.rx_strobe    = rx_strobe;
    assign bus.rx_err       = rx_err;
    assign bus.key_strobe   = key_strobe;
    assign bus.key_code     = key_code;
    assign bus.key_ext      = key_ext;
    assign bus.key_released = key_released;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: drives PS/2 frames on the pins and checks every strobe against
// an event-level model of byte reception and prefix folding.
module tb_ps2_rx;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 300;
    localparam int LAT     = FILTER + 3;

    typedef struct {
        bit         is_err;
        logic [7:0] byte_v;
        logic [1:0] code;
        int         lat;
    } rx_exp_t;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_exp_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   failures = 0;
    int   last_fall_cyc = 0;
    int   n_rx = 0, n_err = 0, n_key = 0;

    rx_exp_t  rx_q[$];
    key_exp_t key_q[$];
    bit       m_ext = 1'b0, m_rel = 1'b0;
    key_exp_t last_key = '{8'h00, 1'b0, 1'b0};
    rx_exp_t  re;
    key_exp_t ke;
    logic     prev_rx_strobe = 1'b0;

    ps2_rx_if bus();

    ps2_rx #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~(^b)) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Event-level reference: what one complete frame must produce.
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_par || bad_stop) begin
            rx_q.push_back('{1'b1, 8'h00, bad_par ? 2'b01 : 2'b10, LAT});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else begin
            rx_q.push_back('{1'b0, b, 2'b00, LAT});
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
            else begin
                key_q.push_back('{b, m_ext, m_rel});
                m_ext = 1'b0;
                m_rel = 1'b0;
            end
        end
    endtask

    task automatic model_timeout();
        rx_q.push_back('{1'b1, 8'h00, 2'b11, LAT + TIMEOUT});
        m_ext = 1'b0;
        m_rel = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int hp);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            wait_cycles(hp);
            bus.ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cycles(hp);
            bus.ps2_clk = 1'b1;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int hp);
        model_frame(b, bad_par, bad_stop);
        send_bits(frame_bits(b, bad_par, bad_stop), 11, hp);
        bus.ps2_data = 1'b1;
        wait_cycles(6);
    endtask

    // Every strobe is matched against the next expected event, including its latency from the pin edge.
    always @(negedge clk_sys) begin
        if (reset) begin
            last_key       = '{8'h00, 1'b0, 1'b0};
            prev_rx_strobe = 1'b0;
        end else begin
            if (bus.rx_strobe || bus.rx_err) begin
                check_output("rx_event_expected", 32'(rx_q.size() > 0), 32'd1);
                if (rx_q.size() > 0) begin
                    re = rx_q.pop_front();
                    check_output("rx_kind", 32'(bus.rx_err), 32'(re.is_err));
                    if (re.is_err) check_output("rx_err_code", 32'(bus.rx_err_code), 32'(re.code));
                    else           check_output("rx_byte", 32'(bus.rx_byte), 32'(re.byte_v));
                    check_output("rx_latency", 32'(cyc - last_fall_cyc), 32'(re.lat));
                end
                if (bus.rx_strobe) n_rx++;
                if (bus.rx_err) n_err++;
            end
            if (bus.key_strobe) begin
                n_key++;
                check_output("key_after_rx", 32'(prev_rx_strobe), 32'd1);
                check_output("key_event_expected", 32'(key_q.size() > 0), 32'd1);
                if (key_q.size() > 0) begin
                    ke = key_q.pop_front();
                    check_output("key_event", 32'({bus.key_code, bus.key_ext, bus.key_released}),
                                 32'({ke.code, ke.ext, ke.rel}));
                    last_key = ke;
                end
            end else begin
                check_output("key_hold", 32'({bus.key_code, bus.key_ext, bus.key_released}),
                             32'({last_key.code, last_key.ext, last_key.rel}));
            end
            prev_rx_strobe = bus.rx_strobe;
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r0, e0, k0, hp, sel;
        logic [7:0] b;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        wait_cycles(4);
        check_output("reset_rx_byte", 32'(bus.rx_byte), 32'h0);
        check_output("reset_rx_strobe", 32'(bus.rx_strobe), 32'h0);
        check_output("reset_rx_err", 32'(bus.rx_err), 32'h0);
        check_output("reset_rx_err_code", 32'(bus.rx_err_code), 32'h0);
        check_output("reset_key_strobe", 32'(bus.key_strobe), 32'h0);
        check_output("reset_key_code", 32'(bus.key_code), 32'h0);
        check_output("reset_key_flags", 32'({bus.key_ext, bus.key_released}), 32'h0);
        check_output("reset_busy", 32'(bus.busy), 32'h0);
        check_output("model_frame_1C", 32'(frame_bits(8'h1C, 1'b0, 1'b0)), 32'h438);
        check_output("model_frame_1C_badpar", 32'(frame_bits(8'h1C, 1'b1, 1'b0)), 32'h638);
        check_output("model_frame_1C_badstop", 32'(frame_bits(8'h1C, 1'b0, 1'b1)), 32'h038);
        reset = 1'b0;
        wait_cycles(3);

        // Single make code
        k0 = n_key; r0 = n_rx;
        apply_stimulus(8'h1C, 1'b0, 1'b0, 20);
        check_output("t1_rx_byte", 32'(bus.rx_byte), 32'h1C);
        check_output("t1_rx_count", 32'(n_rx - r0), 32'd1);
        check_output("t1_key_count", 32'(n_key - k0), 32'd1);
        check_output("t1_key", 32'({bus.key_code, bus.key_ext, bus.key_released}), 32'({8'h1C, 2'b00}));

        // Extended release sequence, then a plain make code
        k0 = n_key; r0 = n_rx;
        apply_stimulus(8'hE0, 1'b0, 1'b0, 18);
        apply_stimulus(8'hF0, 1'b0, 1'b0, 18);
        apply_stimulus(8'h75, 1'b0, 1'b0, 18);
        check_output("t2_rx_count", 32'(n_rx - r0), 32'd3);
        check_output("t2_key_count", 32'(n_key - k0), 32'd1);
        check_output("t2_key", 32'({bus.key_code, bus.key_ext, bus.key_released}), 32'({8'h75, 2'b11}));
        apply_stimulus(8'h1C, 1'b0, 1'b0, 18);
        check_output("t2_key_plain", 32'({bus.key_code, bus.key_ext, bus.key_released}), 32'({8'h1C, 2'b00}));

        // Parity and framing errors
        k0 = n_key; r0 = n_rx; e0 = n_err;
        apply_stimulus(8'h1C, 1'b1, 1'b0, 16);
        check_output("t3_par_code", 32'(bus.rx_err_code), 32'h1);
        apply_stimulus(8'h1C, 1'b0, 1'b1, 16);
        check_output("t3_frame_code", 32'(bus.rx_err_code), 32'h2);
        check_output("t3_err_count", 32'(n_err - e0), 32'd2);
        check_output("t3_no_rx", 32'(n_rx - r0), 32'd0);
        check_output("t3_no_key", 32'(n_key - k0), 32'd0);

        // Stalled frame times out, then the link recovers
        e0 = n_err;
        model_timeout();
        send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 5, 16);
        bus.ps2_data = 1'b1;
        wait_cycles(TIMEOUT + 10);
        check_output("t4_timeout_code", 32'(bus.rx_err_code), 32'h3);
        check_output("t4_err_count", 32'(n_err - e0), 32'd1);
        check_output("t4_busy", 32'(bus.busy), 32'h0);
        apply_stimulus(8'h29, 1'b0, 1'b0, 20);
        check_output("t4_recover", 32'(bus.rx_byte), 32'h29);

        // Short clock glitch is ignored; a longer low pulse with data 0 starts a frame
        bus.ps2_clk = 1'b0;
        wait_cycles(FILTER - 1);
        bus.ps2_clk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check_output("t5_glitch_busy", 32'(bus.busy), 32'h0);
            wait_cycles(1);
        end
        model_timeout();
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        last_fall_cyc = cyc;
        wait_cycles(FILTER + 2);
        bus.ps2_clk = 1'b1;
        wait_cycles(8);
        check_output("t5_pulse_busy", 32'(bus.busy), 32'h1);
        bus.ps2_data = 1'b1;
        wait_cycles(TIMEOUT + 10);
        check_output("t5_idle_again", 32'(bus.busy), 32'h0);

        // Reset in the middle of a frame forgets both the frame and the pending F0
        apply_stimulus(8'hF0, 1'b0, 1'b0, 16);
        r0 = n_rx; e0 = n_err; k0 = n_key;
        send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 3, 16);
        bus.ps2_data = 1'b1;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        m_ext = 1'b0;
        m_rel = 1'b0;
        wait_cycles(TIMEOUT + 10);
        check_output("t6_silent", 32'((n_rx - r0) + (n_err - e0) + (n_key - k0)), 32'd0);
        apply_stimulus(8'h1C, 1'b0, 1'b0, 16);
        check_output("t6_key", 32'({bus.key_code, bus.key_ext, bus.key_released}), 32'({8'h1C, 2'b00}));

        // Randomised traffic biased towards prefixes, with occasional corrupted frames
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(9, 0));
            if (sel < 2)      b = 8'hE0;
            else if (sel < 4) b = 8'hF0;
            else              b = 8'($urandom_range(255, 0));
            hp = int'($urandom_range(24, 14));
            apply_stimulus(b, $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0, hp);
        end

        wait_cycles(20);
        check_output("pending_rx_events", 32'(rx_q.size()), 32'd0);
        check_output("pending_key_events", 32'(key_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host receiver for the core side of the MiST PS/2 link.
- Deserialises the ps2_kbd_clk/ps2_kbd_data (or mouse) frames driven by the IO block's PS/2 transmitter into bytes, in the clk_sys domain.
- Folds keyboard scan-code prefixes (E0 extended, F0 release) into single key events.
- Sits between the IO block's PS/2 outputs and the machine keyboard matrix. For mouse use, only the raw byte outputs are used.

Parameters:
- FILTER, 8: number of consecutive equal synced samples required before a ps2_clk level change is accepted.
- TIMEOUT, 20000: clk_sys cycles without a falling ps2_clk edge inside a frame before the frame is aborted. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk_sys  in  1  system clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock from the transmitter, idle high.
- ps2_data  in  1  PS/2 data, idle high.
- rx_byte  out  8  last correctly received byte.
- rx_strobe  out  1  one-cycle pulse when rx_byte is updated.
- rx_err  out  1  one-cycle pulse when a frame is dropped.
- rx_err_code  out  2  error cause, valid with rx_err: 01 parity, 10 framing (bad stop bit), 11 timeout.
- key_strobe  out  1  one-cycle pulse when a complete key event is available.
- key_code  out  8  scan code of the event.
- key_ext  out  1  an E0 prefix preceded the code.
- key_released  out  1  an F0 prefix preceded the code.
- busy  out  1  deserialiser is not in IDLE.

Behaviour:
- Reset:
  - All outputs 0.
  - Synchronisers and the filtered clock/data reset to 1.
  - FSM goes to IDLE; prefix flags and counters clear.
  - Reset mid-frame discards the partial frame silently: no rx_err, no strobes.
- Input path:
  - Two-flop synchroniser on ps2_clk and ps2_data.
  - clk_f takes the synced clock value only after it has differed from clk_f for FILTER consecutive cycles. Shorter glitches are ignored.
  - fall = clk_f_prev & ~clk_f.
  - Data is sampled from the synced ps2_data in the cycle fall is asserted (the transmitter changes data on the rising edge).
- FSM (advances only on fall, except for timeout):
  - IDLE: data 0 -> DATA, bit_cnt=0. Data 1 -> stay in IDLE; stray edge, no error.
  - DATA: shift register = {data, sr[7:1]} (LSB first). bit_cnt increments; after the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: if data==1 and (^sr ^ parity)==1 (odd parity), then rx_byte<=sr and rx_strobe=1. Else if parity is bad, rx_err code 01. Else (stop bit 0) rx_err code 10. Parity is checked before stop. Always -> IDLE.
- Timing of rx_strobe / rx_err: the cycle after the fall that sampled the stop bit. Total latency from the pin edge = 2 + FILTER + 1 cycles.
- Timeout:
  - Counter runs in every non-IDLE state and clears on fall.
  - On reaching TIMEOUT: -> IDLE with rx_err code 11.
  - If fall and timeout expiry occur in the same cycle, fall wins (counter clears, FSM advances).
- busy = (state != IDLE).
- Prefix decoder (acts on rx_strobe):
  - Byte E0 sets ext_f; byte F0 sets rel_f. Neither produces a key event.
  - Any other byte (including E1, AA, FA): key_strobe pulses one cycle after rx_strobe, with key_code=byte, key_ext=ext_f, key_released=rel_f. Both flags then clear.
  - key_code, key_ext and key_released hold their values until the next key_strobe.
  - Any rx_err clears both flags.
  - A repeated prefix (e.g. E0 E0) keeps the flag set.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Error codes PS2_ERR_PARITY=2'b01, PS2_ERR_FRAME=2'b10, PS2_ERR_TIMEOUT=2'b11.
  - Prefix constants PS2_PFX_EXT=8'hE0, PS2_PFX_REL=8'hF0.
- Sub-module ps2_rx_frame: synchroniser, glitch filter, deserialiser, timeout. Outputs rx_byte, rx_strobe, rx_err, rx_err_code and busy.
- Top ps2_rx: instantiates ps2_rx_frame and holds the prefix decoder.

Test Plan:
- Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> rx_strobe once with rx_byte=1C; key_strobe the next cycle with key_code=1C, key_ext=0, key_released=0.
- Frames E0, F0, 75 -> three rx_strobe, exactly one key_strobe with key_code=75, key_ext=1, key_released=1. A following 0x1C frame gives ext=0, rel=0.
- 0x1C frame with parity 1 -> rx_err, code 01, no rx_strobe, no key_strobe. A 0x1C frame with stop 0 -> rx_err, code 10.
- Start bit plus 4 data bits, then the clock held high for TIMEOUT+10 cycles -> rx_err code 11 exactly TIMEOUT cycles after the last fall, busy 0. A following 0x29 frame is received correctly.
- In IDLE, ps2_clk pulsed low for FILTER-1 cycles -> no state change, busy stays 0. A low pulse of FILTER+2 cycles with data 0 -> busy 1.
- F0 received, then 3 bits of the next frame, then reset asserted for 1 cycle -> no strobes or errors. Next frame 0x1C -> key_strobe with key_released=0.
